// File: rtl/record_uart_serializer_pkg.sv
// Shared definitions for the timetag record to UART byte serializer.
package record_uart_serializer_pkg;

    localparam int REC_BYTES = 6;
    localparam int REC_W     = 8 * REC_BYTES;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2
    } state_t;

endpackage

// File: rtl/record_uart_serializer.sv
// Pulls one record per FIFO read and streams it MSB-first as bytes over a
// valid/ready interface, refetching back-to-back when more records are queued.
module record_uart_serializer #(
    parameter int REC_BYTES = record_uart_serializer_pkg::REC_BYTES,
    parameter int CNT_W     = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   fifo_empty,
    output logic                   fifo_rdreq,
    input  logic [8*REC_BYTES-1:0] fifo_q,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   busy,
    output logic [CNT_W-1:0]       records_sent
);
    import record_uart_serializer_pkg::*;

    localparam int SR_W  = 8 * REC_BYTES;
    localparam int IDX_W = (REC_BYTES > 1) ? $clog2(REC_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REC_BYTES - 1);

    state_t           state;
    logic [SR_W-1:0]  shreg;
    logic [IDX_W-1:0] byte_idx;
    logic             last_accept;

    assign last_accept = (state == ST_SEND) && tx_valid && tx_ready && (byte_idx == LAST_IDX);
    assign fifo_rdreq  = !reset && enable && !fifo_empty && ((state == ST_IDLE) || last_accept);

    // The outgoing byte is always the top of the shift register, so it only
    // moves on an accepted handshake and holds steady under backpressure.
    assign tx_data = shreg[SR_W-1 -: 8];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            shreg        <= '0;
            byte_idx     <= '0;
            tx_valid     <= 1'b0;
            busy         <= 1'b0;
            records_sent <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    tx_valid <= 1'b0;
                    if (fifo_rdreq) begin
                        state <= ST_FETCH;
                        busy  <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    shreg    <= fifo_q;
                    byte_idx <= '0;
                    tx_valid <= 1'b1;
                    busy     <= 1'b1;
                    state    <= ST_SEND;
                end
                ST_SEND: begin
                    if (tx_valid && tx_ready) begin
                        shreg <= shreg << 8;
                        if (last_accept) begin
                            byte_idx     <= '0;
                            records_sent <= records_sent + CNT_W'(1);
                            tx_valid     <= 1'b0;
                            // A read issued on the final accept chains straight into the next record.
                            if (fifo_rdreq) begin
                                state <= ST_FETCH;
                            end else begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            byte_idx <= byte_idx + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_record_uart_serializer.sv
// Directed bench for record_uart_serializer with a normal-mode FIFO model and byte monitor.
module tb_record_uart_serializer;

    localparam logic [47:0] REC_A  = 48'h0123_4567_89AB;
    localparam logic [47:0] REC_B  = 48'hA1B2_C3D4_E5F6;
    localparam logic [47:0] REC_LO = 48'h0000_0000_0001;
    localparam logic [47:0] REC_HI = 48'h7FFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        fifo_empty = 1'b1;
    logic        fifo_rdreq;
    logic [47:0] fifo_q = '0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        busy;
    logic [31:0] records_sent;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int ready_mode = 0;
    int val_cnt = 0;
    int stall_err = 0;
    int stall_seen = 0;
    int rd_empty_err = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;

    logic [7:0]  byte_log[$];
    int          byte_cyc[$];
    int          rd_cyc[$];
    logic [47:0] fifo_mem[$];
    logic [47:0] push_q[$];

    always #5 clk = ~clk;

    record_uart_serializer #(.REC_BYTES(6), .CNT_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .fifo_empty   (fifo_empty),
        .fifo_rdreq   (fifo_rdreq),
        .fifo_q       (fifo_q),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .busy         (busy),
        .records_sent (records_sent)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) tx_ready <= (ready_mode == 2) ? (cyc % 3 == 2) : (ready_mode == 1);

    // Normal-mode FIFO: q updates the cycle after rdreq; writes land on the next edge.
    always @(posedge clk) begin
        if (fifo_rdreq) begin
            if (fifo_mem.size() == 0) rd_empty_err <= rd_empty_err + 1;
            else fifo_q <= fifo_mem.pop_front();
        end
        while (push_q.size() > 0) fifo_mem.push_back(push_q.pop_front());
        fifo_empty <= (fifo_mem.size() == 0);
    end

    always @(negedge clk) begin
        if (fifo_rdreq) rd_cyc.push_back(cyc);
        if (tx_valid) val_cnt <= val_cnt + 1;
        if (tx_valid && tx_ready) begin
            byte_log.push_back(tx_data);
            byte_cyc.push_back(cyc);
        end
        if (!reset && prev_stall && (!tx_valid || tx_data !== prev_data)) stall_err <= stall_err + 1;
        if (tx_valid && !tx_ready) stall_seen <= stall_seen + 1;
        prev_stall <= tx_valid && !tx_ready;
        prev_data  <= tx_data;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int byte_at(int i);
        return (i < byte_log.size()) ? int'(byte_log[i]) : -1;
    endfunction

    function automatic int bcyc_at(int i);
        return (i < byte_cyc.size()) ? byte_cyc[i] : -1000;
    endfunction

    function automatic int rcyc_at(int i);
        return (i < rd_cyc.size()) ? rd_cyc[i] : -1000;
    endfunction

    task automatic check_bytes(input string tag, input int base, input logic [47:0] rec);
        for (int i = 0; i < 6; i++)
            chk($sformatf("%s_byte%0d", tag, i), 64'(byte_at(base + i)), 64'(rec[47-8*i -: 8]));
    endtask

    task automatic wait_sent(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && records_sent != 32'(n); i++) tick();
        chk(tag, 64'(records_sent), 64'(n));
    endtask

    task automatic wait_bytes(input int n, input int budget);
        for (int i = 0; i < budget && byte_log.size() < n; i++) tick();
        chk("byte_wait", 64'(byte_log.size() >= n), 64'd1);
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int b0, b1, r0, v0, s0, ss0;

        // Test 1: single record, always ready
        tick();
        tick();
        chk("rst_tx_valid", 64'(tx_valid), 64'd0);
        chk("rst_tx_data", 64'(tx_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_records_sent", 64'(records_sent), 64'd0);
        chk("rst_rdreq", 64'(fifo_rdreq), 64'd0);
        reset = 1'b0;
        b0 = byte_log.size(); r0 = rd_cyc.size();
        enable = 1'b1; ready_mode = 1;
        push_q.push_back(REC_A);
        wait_sent("t1_sent", 1, 40);
        repeat (3) tick();
        chk("t1_rdreqs", 64'(rd_cyc.size() - r0), 64'd1);
        check_bytes("t1", b0, REC_A);
        chk("t1_latency", 64'(bcyc_at(b0) - rcyc_at(r0)), 64'd2);
        chk("t1_consecutive", 64'(bcyc_at(b0 + 5) - bcyc_at(b0)), 64'd5);
        chk("t1_idle_valid", 64'(tx_valid), 64'd0);
        chk("t1_idle_busy", 64'(busy), 64'd0);

        // Test 2: ready only every third cycle
        reset_dut();
        b0 = byte_log.size(); r0 = rd_cyc.size(); s0 = stall_err; ss0 = stall_seen;
        ready_mode = 2;
        push_q.push_back(REC_A);
        wait_sent("t2_sent", 1, 80);
        repeat (3) tick();
        chk("t2_rdreqs", 64'(rd_cyc.size() - r0), 64'd1);
        check_bytes("t2", b0, REC_A);
        chk("t2_accepts", 64'(byte_log.size() - b0), 64'd6);
        chk("t2_stable", 64'(stall_err - s0), 64'd0);
        chk("t2_stalled", 64'(stall_seen > ss0), 64'd1);

        // Test 3: two queued records back to back
        reset_dut();
        b0 = byte_log.size(); r0 = rd_cyc.size();
        ready_mode = 1;
        push_q.push_back(REC_LO);
        push_q.push_back(REC_HI);
        wait_sent("t3_sent", 2, 60);
        repeat (3) tick();
        check_bytes("t3_rec0", b0, REC_LO);
        check_bytes("t3_rec1", b0 + 6, REC_HI);
        chk("t3_gap", 64'(bcyc_at(b0 + 6) - bcyc_at(b0 + 5)), 64'd2);
        chk("t3_rdreqs", 64'(rd_cyc.size() - r0), 64'd2);

        // Test 4: enable dropped mid-record
        reset_dut();
        b0 = byte_log.size(); r0 = rd_cyc.size();
        push_q.push_back(REC_A);
        push_q.push_back(REC_B);
        wait_bytes(b0 + 2, 40);
        enable = 1'b0;
        repeat (20) tick();
        chk("t4_bytes_done", 64'(byte_log.size() - b0), 64'd6);
        check_bytes("t4_rec0", b0, REC_A);
        chk("t4_rdreqs_held", 64'(rd_cyc.size() - r0), 64'd1);
        chk("t4_busy", 64'(busy), 64'd0);
        chk("t4_sent", 64'(records_sent), 64'd1);
        chk("t4_fifo_pending", 64'(fifo_empty), 64'd0);
        enable = 1'b1;
        wait_sent("t4_sent2", 2, 40);
        check_bytes("t4_rec1", b0 + 6, REC_B);
        chk("t4_rdreqs", 64'(rd_cyc.size() - r0), 64'd2);

        // Test 5: reset mid-record
        reset_dut();
        b0 = byte_log.size();
        push_q.push_back(REC_A);
        push_q.push_back(REC_B);
        wait_bytes(b0 + 3, 40);
        reset = 1'b1;
        #1;
        chk("t5_rst_valid", 64'(tx_valid), 64'd0);
        chk("t5_rst_sent", 64'(records_sent), 64'd0);
        chk("t5_rst_busy", 64'(busy), 64'd0);
        chk("t5_rst_rdreq", 64'(fifo_rdreq), 64'd0);
        tick();
        reset = 1'b0;
        b1 = byte_log.size();
        chk("t5_partial", 64'(b1 - b0), 64'd3);
        wait_sent("t5_sent", 1, 40);
        check_bytes("t5_next", b1, REC_B);

        // Test 6: empty FIFO with enable high
        reset_dut();
        r0 = rd_cyc.size(); v0 = val_cnt;
        repeat (100) tick();
        chk("t6_rdreqs", 64'(rd_cyc.size() - r0), 64'd0);
        chk("t6_valid_cycles", 64'(val_cnt - v0), 64'd0);
        chk("t6_tx_valid", 64'(tx_valid), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("empty_reads", 64'(rd_empty_err), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
